// File: rtl/apb_master_bridge.sv
// APB requester: turns one valid/ready command into a single APB SETUP/ACCESS transfer
// and returns the outcome on a valid/ready response channel.
module apb_master_bridge #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout,
  output logic              busy,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  // The counter only ever reaches TIMEOUT-1 before the abort fires.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t            state, state_d;
  logic              psel_d, penable_d, pwrite_d;
  logic [ADDR_W-1:0] paddr_d;
  logic [DATA_W-1:0] pwdata_d, rsp_rdata_d;
  logic              rsp_valid_d, rsp_err_d, rsp_timeout_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              misaligned, cnt_expired;

  assign cmd_ready   = (state == IDLE) && rst;
  assign busy        = (state != IDLE);
  assign misaligned  = (cmd_addr[1:0] != 2'b00);
  assign cnt_expired = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d       = state;
    psel_d        = psel;
    penable_d     = penable;
    pwrite_d      = pwrite;
    paddr_d       = paddr;
    pwdata_d      = pwdata;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    cnt_d         = cnt;

    case (state)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          pwrite_d = cmd_write;
          paddr_d  = cmd_addr;
          pwdata_d = cmd_wdata;
          // Misaligned requests are answered locally without touching the bus.
          if (misaligned) begin
            state_d       = RESP;
            rsp_valid_d   = 1'b1;
            rsp_err_d     = 1'b1;
            rsp_timeout_d = 1'b0;
            rsp_rdata_d   = '0;
          end else begin
            state_d   = SETUP;
            psel_d    = 1'b1;
            penable_d = 1'b0;
          end
        end
      end

      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end

      ACCESS: begin
        if (pready) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_rdata_d   = pwrite ? '0 : prdata;
        end else if (cnt_expired) begin
          state_d       = RESP;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_rdata_d   = '0;
        end else if (TIMEOUT != 0) begin
          cnt_d = cnt + 1'b1;
        end
      end

      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // Asynchronous reset drops the bus immediately and discards any pending response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      psel        <= 1'b0;
      penable     <= 1'b0;
      pwrite      <= 1'b0;
      paddr       <= '0;
      pwdata      <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      cnt         <= '0;
    end else begin
      state       <= state_d;
      psel        <= psel_d;
      penable     <= penable_d;
      pwrite      <= pwrite_d;
      paddr       <= paddr_d;
      pwdata      <= pwdata_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      cnt         <= cnt_d;
    end
  end

endmodule

// File: tb/tb_apb_master_bridge.sv
// Bench for apb_master_bridge: behavioural APB slave plus a transaction-level model of
// the expected response, latency and bus activity for each command.
module tb_apb_master_bridge;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err, rsp_timeout, busy;
  logic          psel, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata, prdata;
  logic          pready, pslverr;

  always #5 clk = ~clk;

  apb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  int total = 0;
  int bad   = 0;

  logic [31:0] slave_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];

  logic        obs_done, obs_err, obs_to, obs_pwrite;
  logic        obs_addr_stable, obs_rsp_stable, obs_ready_leak;
  logic [31:0] obs_rdata, obs_paddr, obs_pwdata;
  int          obs_cycles, obs_psel, obs_pen, obs_access, obs_first_psel, obs_first_pen;

  logic        exp_err, exp_to;
  logic [31:0] exp_rdata;
  int          exp_access, exp_cycles;

  // Unwritten slave locations read back as a fixed function of their address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return a ^ 32'hC3C3_0000;
  endfunction

  // Transaction-level prediction: outcome, ACCESS count and accept-to-ready latency.
  task automatic predict(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int wait_n, input logic serr, input int hold);
    if (a[1:0] != 2'b00) begin
      exp_err = 1'b1; exp_to = 1'b0; exp_rdata = 32'd0;
      exp_access = 0; exp_cycles = 2 + hold;
    end else if (TO != 0 && wait_n >= TO) begin
      exp_err = 1'b1; exp_to = 1'b1; exp_rdata = 32'd0;
      exp_access = TO; exp_cycles = TO + 3 + hold;
    end else begin
      exp_err = serr; exp_to = 1'b0;
      exp_access = wait_n + 1; exp_cycles = wait_n + 4 + hold;
      exp_rdata = w ? 32'd0 : (ref_mem.exists(a) ? ref_mem[a] : dflt(a));
      if (w && !serr) ref_mem[a] = d;
    end
  endtask

  // Issues one command, plays the slave side cycle by cycle and records what it saw.
  task automatic run_xfer(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input int wait_n, input logic serr, input int hold);
    int cyc;
    int guard;
    int rsp_seen;
    obs_done = 1'b0; obs_cycles = 0; obs_psel = 0; obs_pen = 0; obs_access = 0;
    obs_first_psel = -1; obs_first_pen = -1; obs_addr_stable = 1'b1;
    obs_rsp_stable = 1'b1; obs_ready_leak = 1'b0; rsp_seen = 0;
    obs_rdata = 32'd0; obs_err = 1'b0; obs_to = 1'b0;
    obs_paddr = 32'd0; obs_pwdata = 32'd0; obs_pwrite = 1'b0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; rsp_ready = 1'b1;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    cyc = 0;
    while (!obs_done && cyc < 100) begin
      @(posedge clk); #1; cyc++;
      if (cyc == 1) begin
        cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom;
      end
      if (psel) begin
        obs_psel++;
        if (obs_first_psel < 0) begin
          obs_first_psel = cyc; obs_paddr = paddr; obs_pwdata = pwdata; obs_pwrite = pwrite;
        end else if (paddr !== obs_paddr || pwdata !== obs_pwdata || pwrite !== obs_pwrite)
          obs_addr_stable = 1'b0;
      end
      if (penable) begin
        obs_pen++;
        if (obs_first_pen < 0) obs_first_pen = cyc;
      end
      if (psel && penable) begin
        obs_access++;
        if (obs_access > wait_n) begin
          pready = 1'b1; pslverr = serr;
          prdata = pwrite ? $urandom : (slave_mem.exists(paddr) ? slave_mem[paddr] : dflt(paddr));
          if (pwrite && !serr) slave_mem[paddr] = pwdata;
        end else begin
          pready = 1'b0; pslverr = 1'($urandom); prdata = $urandom;
        end
      end else begin
        pready = 1'b0; pslverr = 1'b0; prdata = $urandom;
      end
      if (rsp_valid) begin
        if (rsp_seen == 0) begin
          obs_rdata = rsp_rdata; obs_err = rsp_err; obs_to = rsp_timeout;
        end else if (rsp_rdata !== obs_rdata || rsp_err !== obs_err || rsp_timeout !== obs_to)
          obs_rsp_stable = 1'b0;
        rsp_ready = (rsp_seen >= hold);
        rsp_seen++;
      end else begin
        rsp_ready = 1'b1;
      end
      if (cmd_ready && (rsp_seen == 0 || rsp_valid)) obs_ready_leak = 1'b1;
      if (rsp_seen > 0 && !rsp_valid && cmd_ready) begin
        obs_done = 1'b1; obs_cycles = cyc;
      end
    end
    pready = 1'b0; rsp_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy} !== 7'b0) begin
      bad++; $display("[TB] FAIL reset_ctrl got %b want 0000000", {psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, busy}); end
    total++; if ({paddr, pwdata, rsp_rdata} !== 96'd0) begin
      bad++; $display("[TB] FAIL reset_data got %h want 0", {paddr, pwdata, rsp_rdata}); end
    total++; if (cmd_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_cmd_ready got %b want 0", cmd_ready); end
    rst = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL release_cmd_ready got %b want 1", cmd_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_write_read();
    predict(1'b1, 32'h4, 32'hA5A5_1234, 0, 1'b0, 0);
    run_xfer(1'b1, 32'h4, 32'hA5A5_1234, 0, 1'b0, 0);
    total++; if (!obs_done) begin bad++; $display("[TB] FAIL wr_done got 0 want 1"); end
    total++; if ({obs_err, obs_to, obs_rdata} !== {exp_err, exp_to, exp_rdata}) begin
      bad++; $display("[TB] FAIL wr_rsp got %b/%b/%h want %b/%b/%h", obs_err, obs_to, obs_rdata, exp_err, exp_to, exp_rdata); end
    total++; if (obs_cycles !== 4) begin bad++; $display("[TB] FAIL wr_latency got %0d want 4", obs_cycles); end
    total++; if (obs_psel !== 2 || obs_pen !== 1 || obs_first_pen !== obs_first_psel + 1) begin
      bad++; $display("[TB] FAIL wr_phases got psel=%0d pen=%0d want psel=2 pen=1 in 2nd", obs_psel, obs_pen); end
    total++; if ({obs_pwrite, obs_paddr, obs_pwdata} !== {1'b1, 32'h4, 32'hA5A5_1234}) begin
      bad++; $display("[TB] FAIL wr_bus got %b %h %h want 1 4 a5a51234", obs_pwrite, obs_paddr, obs_pwdata); end

    predict(1'b0, 32'h4, 32'h1357_9BDF, 0, 1'b0, 0);
    run_xfer(1'b0, 32'h4, 32'h1357_9BDF, 0, 1'b0, 0);
    total++; if (obs_rdata !== 32'hA5A5_1234 || obs_err !== 1'b0) begin
      bad++; $display("[TB] FAIL rd_data got %h err=%b want a5a51234 err=0", obs_rdata, obs_err); end
    total++; if (obs_cycles !== 4 || obs_psel !== 2 || obs_pen !== 1) begin
      bad++; $display("[TB] FAIL rd_timing got cyc=%0d psel=%0d pen=%0d want 4 2 1", obs_cycles, obs_psel, obs_pen); end
    total++; if ({obs_pwrite, obs_pwdata} !== {1'b0, 32'h1357_9BDF}) begin
      bad++; $display("[TB] FAIL rd_pwdata got %b %h want 0 13579bdf", obs_pwrite, obs_pwdata); end
  endtask

  task automatic test_wait_states();
    slave_mem[32'h8] = 32'h0000_00FF;
    ref_mem[32'h8]   = 32'h0000_00FF;
    predict(1'b0, 32'h8, $urandom, 3, 1'b0, 0);
    run_xfer(1'b0, 32'h8, $urandom, 3, 1'b0, 0);
    total++; if (obs_access !== 4 || obs_psel !== 5) begin
      bad++; $display("[TB] FAIL ws_access got acc=%0d psel=%0d want 4 5", obs_access, obs_psel); end
    total++; if (!obs_addr_stable || obs_paddr !== 32'h8) begin
      bad++; $display("[TB] FAIL ws_stable got stable=%b addr=%h want 1 8", obs_addr_stable, obs_paddr); end
    total++; if (obs_rdata !== 32'hFF || obs_cycles !== exp_cycles) begin
      bad++; $display("[TB] FAIL ws_rsp got %h cyc=%0d want ff cyc=%0d", obs_rdata, obs_cycles, exp_cycles); end
  endtask

  task automatic test_slave_error();
    predict(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 1'b1, 0);
    run_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, 0, 1'b1, 0);
    total++; if ({obs_err, obs_to, obs_rdata} !== {1'b1, 1'b0, 32'd0}) begin
      bad++; $display("[TB] FAIL slverr_rsp got %b/%b/%h want 1/0/0", obs_err, obs_to, obs_rdata); end
  endtask

  task automatic test_timeout();
    predict(1'b0, 32'h10, $urandom, 10, 1'b0, 0);
    run_xfer(1'b0, 32'h10, $urandom, 10, 1'b0, 0);
    total++; if (!obs_done || obs_access !== TO || obs_psel !== TO + 1) begin
      bad++; $display("[TB] FAIL to_access got done=%b acc=%0d psel=%0d want 1 %0d %0d", obs_done, obs_access, obs_psel, TO, TO + 1); end
    total++; if ({obs_err, obs_to, obs_rdata} !== {1'b1, 1'b1, 32'd0}) begin
      bad++; $display("[TB] FAIL to_rsp got %b/%b/%h want 1/1/0", obs_err, obs_to, obs_rdata); end
    predict(1'b0, 32'h10, $urandom, TO - 1, 1'b0, 0);
    run_xfer(1'b0, 32'h10, $urandom, TO - 1, 1'b0, 0);
    total++; if ({obs_err, obs_to, obs_rdata} !== {1'b0, 1'b0, exp_rdata} || obs_access !== TO) begin
      bad++; $display("[TB] FAIL to_edge got %b/%b/%h acc=%0d want 0/0/%h acc=%0d", obs_err, obs_to, obs_rdata, obs_access, exp_rdata, TO); end
  endtask

  task automatic test_misaligned_backpressure();
    predict(1'b0, 32'h6, 32'h0, 0, 1'b0, 5);
    run_xfer(1'b0, 32'h6, 32'h0, 0, 1'b0, 5);
    total++; if (obs_psel !== 0) begin bad++; $display("[TB] FAIL mis_psel got %0d want 0", obs_psel); end
    total++; if ({obs_err, obs_to, obs_rdata} !== {1'b1, 1'b0, 32'd0}) begin
      bad++; $display("[TB] FAIL mis_rsp got %b/%b/%h want 1/0/0", obs_err, obs_to, obs_rdata); end
    total++; if (!obs_rsp_stable || obs_ready_leak) begin
      bad++; $display("[TB] FAIL bp_hold got stable=%b leak=%b want 1 0", obs_rsp_stable, obs_ready_leak); end
    total++; if (obs_cycles !== 7) begin bad++; $display("[TB] FAIL bp_latency got %0d want 7", obs_cycles); end
  endtask

  task automatic test_reset_mid_access();
    int guard;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h20; cmd_wdata = 32'h0; pready = 1'b0;
    guard = 0;
    while (!cmd_ready && guard < 50) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    guard = 0;
    while (!(psel && penable) && guard < 20) begin @(posedge clk); #1; guard++; end
    total++; if (!(psel && penable)) begin bad++; $display("[TB] FAIL mid_reach got 0 want 1"); end
    #2;
    rst = 1'b0;
    #1;
    total++; if ({psel, penable, rsp_valid, busy, cmd_ready} !== 5'b0) begin
      bad++; $display("[TB] FAIL mid_reset got %b want 00000", {psel, penable, rsp_valid, busy, cmd_ready}); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    total++; if (cmd_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_release got %b want 1", cmd_ready); end
    predict(1'b0, 32'h4, $urandom, 1, 1'b0, 0);
    run_xfer(1'b0, 32'h4, $urandom, 1, 1'b0, 0);
    total++; if (!obs_done || {obs_err, obs_rdata} !== {1'b0, 32'hA5A5_1234}) begin
      bad++; $display("[TB] FAIL mid_after got done=%b %b/%h want 1 0/a5a51234", obs_done, obs_err, obs_rdata); end
  endtask

  task automatic test_random();
    logic        w, serr;
    logic [31:0] a, d;
    int          wait_n, hold;
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom); d = $urandom;
      a = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      wait_n = $urandom_range(0, 5);
      serr = ($urandom_range(0, 7) == 0);
      hold = $urandom_range(0, 2);
      predict(w, a, d, wait_n, serr, hold);
      run_xfer(w, a, d, wait_n, serr, hold);
      total++; if (!obs_done) begin bad++; $display("[TB] FAIL rnd%0d_done got 0 want 1", i); end
      total++; if ({obs_err, obs_to, obs_rdata} !== {exp_err, exp_to, exp_rdata}) begin
        bad++; $display("[TB] FAIL rnd%0d_rsp got %b/%b/%h want %b/%b/%h", i, obs_err, obs_to, obs_rdata, exp_err, exp_to, exp_rdata); end
      total++; if (obs_access !== exp_access || obs_cycles !== exp_cycles) begin
        bad++; $display("[TB] FAIL rnd%0d_timing got acc=%0d cyc=%0d want acc=%0d cyc=%0d", i, obs_access, obs_cycles, exp_access, exp_cycles); end
      total++; if (obs_ready_leak || !obs_rsp_stable || !obs_addr_stable) begin
        bad++; $display("[TB] FAIL rnd%0d_proto got leak=%b rs=%b as=%b want 0 1 1", i, obs_ready_leak, obs_rsp_stable, obs_addr_stable); end
    end
  endtask

  initial begin
    rst = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 32'd0; cmd_wdata = 32'd0;
    rsp_ready = 1'b1; prdata = 32'd0; pready = 1'b0; pslverr = 1'b0;
    test_reset();
    test_write_read();
    test_wait_states();
    test_slave_error();
    test_timeout();
    test_misaligned_backpressure();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
